seq_scan_ctrl: RTL and testbench

Word-level scheduler that feeds parallel words, one bit per cycle, MSB first, into an overlapping Mealy "1011" sequence detector. It reports a per-word match count and hit map over a valid/ready output. It sits between a parallel producer (valid/ready) and a consumer of match statistics, and owns the detector's enable and clear. Detector state is optionally carried across word boundaries so patterns spanning two words are detected.

---
 rtl/seq_pkg.sv | 23 ++
 rtl/seq1011_core.sv | 48 ++++
 rtl/seq_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_seq_scan_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg
// Shared types and constants for the word-level "1011" scan controller.
//   scan_state_e : controller FSM encoding (IDLE / SHIFT / REPORT)
//   det_state_e  : Mealy detector encoding (s0 / s1 / s2 / s3)
//   PATTERN      : the bit sequence the detector recognises, first bit in [3]
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2
    } scan_state_e;

    typedef enum logic [1:0] {
        DET_S0 = 2'd0,  // nothing matched
        DET_S1 = 2'd1,  // seen "1"
        DET_S2 = 2'd2,  // seen "10"
        DET_S3 = 2'd3   // seen "101"
    } det_state_e;

    localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq1011_core.sv
// seq1011_core
// Overlapping Mealy detector for the serial pattern "1011".
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, returns the detector to s0
//   clr   : synchronous clear to s0, wins over en
//   en    : advance the detector by one bit
//   din   : serial input bit
//   dout  : combinational match flag, high in the cycle the final '1' arrives
module seq1011_core
    import seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic dout
);

    det_state_e state_q;
    det_state_e state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            DET_S0:  state_d = din ? DET_S1 : DET_S0;
            DET_S1:  state_d = din ? DET_S1 : DET_S2;
            DET_S2:  state_d = din ? DET_S3 : DET_S0;
            // A completed match leaves a trailing '1' that starts the next one.
            DET_S3:  state_d = din ? DET_S1 : DET_S2;
            default: state_d = DET_S0;
        endcase
    end

    assign dout = en && (state_q == DET_S3) && (din == PATTERN[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DET_S0;
        end else if (clr) begin
            state_q <= DET_S0;
        end else if (en) begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
// Accepts a parallel word, feeds it MSB first into the "1011" detector one bit
// per cycle, and reports the number of matches and a per-bit hit map.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid/in_ready       : word input handshake, in_data is the word
//   carry_en                : 1 keeps detector state from the previous word
//   out_valid/out_ready     : result handshake
//   out_count, out_hit_map  : matches in the word, bit i set if in_data[i]
//                             completed a match
//   busy                    : high while a word is being scanned or reported
//   dbg_state               : current controller FSM state
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in REPORT
// and the result stays stable until the transfer. Valid is ignored while
// ready is low.
module seq_scan_ctrl
    import seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             carry_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [WIDTH-1:0] out_hit_map,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] SHIFT  = ST_SHIFT;
    localparam logic [1:0] REPORT = ST_REPORT;

    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] COUNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state;
    logic [WIDTH-1:0] word_q;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] hit_q;

    logic accept;
    logic det_clr;
    logic det_en;
    logic det_din;
    logic det_dout;

    assign accept  = (state == IDLE) && in_valid;
    // The clear lands on the acceptance edge, so it can never meet a shift.
    assign det_clr = accept && !carry_en;
    assign det_en  = (state == SHIFT);
    assign det_din = word_q[idx];

    seq1011_core u_core (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (det_clr),
        .en   (det_en),
        .din  (det_din),
        .dout (det_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            word_q  <= '0;
            idx     <= '0;
            count_q <= '0;
            hit_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word_q  <= in_data;
                        idx     <= IDX_TOP;
                        count_q <= '0;
                        hit_q   <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (det_dout) begin
                        if (count_q != COUNT_MAX) begin
                            count_q <= count_q + CNT_W'(1);
                        end
                        hit_q[idx] <= 1'b1;
                    end
                    if (idx == '0) begin
                        state <= REPORT;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == REPORT);
    assign busy        = (state == SHIFT) || (state == REPORT);
    assign out_count   = count_q;
    assign out_hit_map = hit_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl
// Directed bench for seq_scan_ctrl with hand-computed expectations.
module tb_seq_scan_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             carry_en;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic [WIDTH-1:0] out_hit_map;
    logic             busy;
    logic [1:0]       dbg_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .carry_en   (carry_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .out_hit_map(out_hit_map),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents a word, waits for the accepting edge, ends at the negedge
    // inside the first SHIFT cycle.
    task automatic start_word(input logic [WIDTH-1:0] d, input logic c);
        @(negedge clk);
        in_data  = d;
        carry_en = c;
        in_valid = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h5A;
        carry_en = 1'b0;
        @(negedge clk);
        check("in_ready_low_after_accept", 32'(in_ready), 32'd0);
        check("busy_shift", 32'(busy), 32'd1);
    endtask

    // Counts edges after acceptance until out_valid is seen; ends at a negedge
    // inside REPORT.
    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
    endtask

    task automatic finish_handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("out_valid_after_hs", 32'(out_valid), 32'd0);
        check("in_ready_after_hs", 32'(in_ready), 32'd1);
    endtask

    task automatic do_word(input string tag, input logic [WIDTH-1:0] d, input logic c,
                           input logic [CNT_W-1:0] exp_cnt, input logic [WIDTH-1:0] exp_map);
        start_word(d, c);
        wait_result(tag);
        check({tag, "_count"}, 32'(out_count), 32'(exp_cnt));
        check({tag, "_hit_map"}, 32'(out_hit_map), 32'(exp_map));
        finish_handshake();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_count"}, 32'(out_count), 32'd0);
        check({tag, "_out_hit_map"}, 32'(out_hit_map), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        carry_en  = 1'b0;
        out_ready = 1'b0;
        #2;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Overlapping matches inside one word.
        do_word("overlap", 8'b1011_0110, 1'b0, 4'd2, 8'b0001_0010);
        do_word("trailing", 8'b1011_1011, 1'b0, 4'd2, 8'b0001_0001);

        // Pattern spanning two words: "101" ends word one, "1" starts word two.
        do_word("cross_a", 8'b0000_0101, 1'b0, 4'd0, 8'h00);
        do_word("cross_carry", 8'b1000_0000, 1'b1, 4'd1, 8'b1000_0000);
        do_word("cross_b", 8'b0000_0101, 1'b0, 4'd0, 8'h00);
        do_word("cross_nocarry", 8'b1000_0000, 1'b0, 4'd0, 8'h00);

        // Backpressure: result must hold and no new word may slip in.
        start_word(8'b1011_0110, 1'b0);
        wait_result("bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_data  = 8'hFF;
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_count", 32'(out_count), 32'd2);
            check("bp_hit_map", 32'(out_hit_map), 32'h12);
        end
        in_valid = 1'b0;
        finish_handshake();
        @(negedge clk);
        check("bp_idle_busy", 32'(busy), 32'd0);
        check("bp_idle_state", 32'(dbg_state), 32'd0);

        // Leave the detector in s1, then advance it to s3 with a carried word
        // and reset during its third SHIFT cycle.
        do_word("pre_reset", 8'b0000_0001, 1'b0, 4'd0, 8'h00);
        start_word(8'b0100_0000, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        // A detector still in s3 would add a match at bit 7.
        do_word("post_reset", 8'b1011_0000, 1'b1, 4'd1, 8'b0001_0000);

        // All-ones ends in s1, all-zeros ends in s0; probe each with a carried word.
        do_word("ones", 8'hFF, 1'b0, 4'd0, 8'h00);
        do_word("ones_probe", 8'b0110_0000, 1'b1, 4'd1, 8'b0010_0000);
        do_word("zeros", 8'h00, 1'b0, 4'd0, 8'h00);
        do_word("zeros_probe", 8'b0110_0000, 1'b1, 4'd0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
